// File: rtl/addr_key_unlock_pkg.sv
// addr_key_pkg: shared types and helpers for the address-key unlock latch.
//   state_t    : LOCKED while collecting key nibbles, OPEN once unlocked.
//   key_nib    : extracts step i (0..7) from the packed 32-bit key.
//   lfsr_next  : one shift of a left-shifting Fibonacci LFSR, feedback into
//                bit 0. Works on a 32-bit container; callers keep the low
//                bits they need.
package addr_key_pkg;

   typedef enum logic {LOCKED = 1'b0, OPEN = 1'b1} state_t;

   function automatic logic [3:0] key_nib(input logic [31:0] key, input int i);
      return key[4*i +: 4];
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] v, input logic [31:0] taps);
      return {v[30:0], ^(v & taps)};
   endfunction

endpackage

// File: rtl/addr_key_unlock_if.sv
// addr_key_unlock_if: snooped bus access plus the two-lane read response.
//   bus_valid : one-cycle strobe per access
//   ssel_n    : active-low slot select
//   ba        : bus address
//   br_w      : 1 = read, 0 = write
//   rd_oe     : per-lane drive enable (one-hot or zero)
//   rd_d      : per-lane response data
interface addr_key_unlock_if #(parameter int ADDR_W = 14);
   logic              bus_valid;
   logic              ssel_n;
   logic [ADDR_W-1:0] ba;
   logic              br_w;
   logic [1:0]        rd_oe;
   logic [1:0]        rd_d;

   modport master (output bus_valid, ssel_n, ba, br_w, input rd_oe, rd_d);
   modport slave  (input bus_valid, ssel_n, ba, br_w, output rd_oe, rd_d);
endinterface

// File: rtl/addr_key_unlock_resp_lfsr.sv
// resp_lfsr: response bit generator.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   load       : reload SEED (takes priority over adv)
//   adv        : advance one step
//   bit_o      : current response bit, q[0]
module resp_lfsr
   import addr_key_pkg::*;
#(
   parameter int           W    = 6,
   parameter logic [W-1:0] TAPS = 6'h30,
   parameter logic [W-1:0] SEED = 6'h01
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic adv,
   output logic bit_o
);

   logic [W-1:0] q;
   logic [31:0]  nxt;

   assign nxt   = lfsr_next(32'(q), 32'(TAPS));
   assign bit_o = q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= SEED;
      else if (load) q <= SEED;
      else if (adv)  q <= nxt[W-1:0];
   end

endmodule

// File: rtl/addr_key_unlock.sv
// addr_key_unlock: bus-snooping security latch.
// Reads that hit the address window must present KEY nibble by nibble; once
// the whole key is seen the block opens and answers each decoded read with an
// LFSR bit on one of two data lanes, alternating lanes per read. Any write
// hit relocks.
//   clk, rst_n : clock, async active-low reset
//   bus        : snooped access in, two-lane response out
//   unlocked   : high while OPEN
//   step       : key progress (KEY_LEN while OPEN)
module addr_key_unlock
   import addr_key_pkg::*;
#(
   parameter int                ADDR_W    = 14,
   parameter logic [ADDR_W-1:0] WIN_MASK  = 14'h3000,
   parameter logic [ADDR_W-1:0] WIN_MATCH = 14'h1000,
   parameter int                NIB_LSB   = 4,
   parameter int                KEY_LEN   = 4,
   parameter logic [31:0]       KEY       = 32'h0000_C9A2,
   parameter int                LFSR_W    = 6,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 6'h30,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 6'h01,
   parameter int                TIMEOUT   = 0,
   localparam int               SW        = $clog2(KEY_LEN+1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   addr_key_unlock_if.slave       bus,
   output logic                   unlocked,
   output logic [SW-1:0]          step
);

   localparam int            TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

   state_t        state_q, state_d;
   logic [SW-1:0] step_q, step_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          lane_q, lane_d;
   logic          lfsr_load, lfsr_adv, lfsr_bit;
   logic          hit;
   logic [3:0]    nib;
   logic [1:0]    oe_c, d_c;

   assign hit = bus.bus_valid & ~bus.ssel_n & ((bus.ba & WIN_MASK) == WIN_MATCH);
   assign nib = bus.ba[NIB_LSB +: 4];

   resp_lfsr #(.W(LFSR_W), .TAPS(LFSR_TAPS), .SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .adv   (lfsr_adv),
      .bit_o (lfsr_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOCKED;
         step_q  <= '0;
         idle_q  <= '0;
         lane_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         idle_q  <= idle_d;
         lane_q  <= lane_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      idle_d    = idle_q;
      lane_d    = lane_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      oe_c      = 2'b00;
      d_c       = 2'b00;
      case (state_q)
         LOCKED: begin
            if (hit) begin
               idle_d = '0;
               if (bus.br_w) begin
                  if (nib == key_nib(KEY, int'(step_q))) begin
                     if (step_q == SW'(KEY_LEN-1)) begin
                        state_d   = OPEN;
                        step_d    = SW'(KEY_LEN);
                        lfsr_load = 1'b1;
                        lane_d    = 1'b0;
                     end else begin
                        step_d = step_q + 1'b1;
                     end
                  end else begin
                     // only recovery: a wrong nibble that is itself the first key nibble
                     step_d = (nib == key_nib(KEY, 0)) ? SW'(1) : '0;
                  end
               end else begin
                  step_d = '0;
               end
            end else if (TIMEOUT > 0 && step_q != '0) begin
               if (idle_q == TO_LAST) begin
                  step_d = '0;
                  idle_d = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end
         OPEN: begin
            if (hit) begin
               if (bus.br_w) begin
                  oe_c[lane_q] = 1'b1;
                  d_c[lane_q]  = lfsr_bit;
                  lfsr_adv     = 1'b1;
                  lane_d       = ~lane_q;
               end else begin
                  state_d = LOCKED;
                  step_d  = '0;
                  idle_d  = '0;
               end
            end
         end
         default: state_d = LOCKED;
      endcase
   end

   assign bus.rd_oe = oe_c;
   assign bus.rd_d  = d_c;
   assign unlocked  = (state_q == OPEN);
   assign step      = step_q;

endmodule
